stopwatch_core_gen: RTL and testbench

- Parametrised stopwatch/countdown timing core. It holds 6 BCD digits: MM:SS.cc.
- Adds three features: a lap buffer of configurable depth, a timer auto-repeat mode, and an up-count wrap-or-saturate policy.
- Inputs are single-cycle command pulses from debounced keys plus a 10 ms tick. Output is a display-ready BCD word for the segment scanner.
- Contains no debounce, tick generation or display scanning; those stay in the top level.

---
 rtl/stopwatch_pkg.sv | 36 +++
 rtl/bcd_time_counter.sv | 79 +++++++
 rtl/stopwatch_core_gen.sv | 214 +++++++++++++++++++++
 tb/tb_stopwatch_core_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch timing core: BCD digit and
// MM:SS.cc time word, digit limits and the preset clamp.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m_t;
    bcd_t m_o;
    bcd_t s_t;
    bcd_t s_o;
    bcd_t c_t;
    bcd_t c_o;
  } sw_time_t;

  localparam sw_time_t TIME_ZERO    = '0;
  localparam sw_time_t TIME_ONE_CC  = 24'h000001;
  localparam bcd_t     SEC_TENS_MAX = 4'd5;
  localparam bcd_t     ONES_MAX     = 4'd9;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  // Preset keys give MM,SS only; hundredths always start at 00.
  function automatic sw_time_t clamp_preset(input logic [15:0] preset, input bcd_t min_tens_max);
    sw_time_t t;
    t     = TIME_ZERO;
    t.m_t = clamp_digit(preset[15:12], min_tens_max);
    t.m_o = clamp_digit(preset[11:8], ONES_MAX);
    t.s_t = clamp_digit(preset[7:4], SEC_TENS_MAX);
    t.s_o = clamp_digit(preset[3:0], ONES_MAX);
    return t;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Six-digit BCD MM:SS.cc up/down counter with parallel load; load wins over
// counting, and both directions wrap at the ends of the range.
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  sw_time_t load_value,
  input  logic     inc,
  input  logic     dec,
  output sw_time_t value,
  output logic     is_zero,
  output logic     is_max
);

  localparam sw_time_t TIME_MAX = '{m_t: bcd_t'(MIN_TENS_MAX), m_o: ONES_MAX,
                                    s_t: SEC_TENS_MAX, s_o: ONES_MAX,
                                    c_t: ONES_MAX, c_o: ONES_MAX};

  bcd_t     digits    [6];
  bcd_t     limits    [6];
  bcd_t     up_digits [6];
  bcd_t     dn_digits [6];
  sw_time_t up_value;
  sw_time_t dn_value;

  // Ripple carry/borrow from hundredths upward, each digit with its own limit.
  always_comb begin
    logic carry;
    logic borrow;
    digits = '{value.c_o, value.c_t, value.s_o, value.s_t, value.m_o, value.m_t};
    limits = '{ONES_MAX, ONES_MAX, ONES_MAX, SEC_TENS_MAX, ONES_MAX, bcd_t'(MIN_TENS_MAX)};
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_digits[i] = digits[i];
      dn_digits[i] = digits[i];
      if (carry) begin
        if (digits[i] == limits[i]) begin
          up_digits[i] = 4'd0;
        end else begin
          up_digits[i] = digits[i] + 4'd1;
          carry        = 1'b0;
        end
      end
      if (borrow) begin
        if (digits[i] == 4'd0) begin
          dn_digits[i] = limits[i];
        end else begin
          dn_digits[i] = digits[i] - 4'd1;
          borrow       = 1'b0;
        end
      end
    end
    up_value = '{m_t: up_digits[5], m_o: up_digits[4], s_t: up_digits[3],
                 s_o: up_digits[2], c_t: up_digits[1], c_o: up_digits[0]};
    dn_value = '{m_t: dn_digits[5], m_o: dn_digits[4], s_t: dn_digits[3],
                 s_o: dn_digits[2], c_t: dn_digits[1], c_o: dn_digits[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= TIME_ZERO;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= up_value;
    end else if (dec) begin
      value <= dn_value;
    end
  end

  assign is_zero = (value == TIME_ZERO);
  assign is_max  = (value == TIME_MAX);

endmodule

// File: rtl/stopwatch_core_gen.sv
// Stopwatch / countdown timing core: BCD MM:SS.cc count driven by a 10 ms
// tick and key pulses, with lap buffer, timer auto-repeat and up-count wrap policy.
module stopwatch_core_gen
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH    = 4,
  parameter int MIN_TENS_MAX = 5,
  parameter bit SATURATE     = 1'b0,
  parameter int LW           = $clog2(LAP_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic          cmd_load,
  input  logic          cmd_mode,
  input  logic          cmd_lap,
  input  logic          cmd_clear,
  input  logic          repeat_en,
  input  logic [15:0]   preset_bcd,
  output logic [23:0]   disp_bcd,
  output logic          running,
  output logic          mode_timer,
  output logic          done,
  output logic          event_pulse,
  output logic [LW:0]   lap_count,
  output logic          viewing_lap,
  output logic [LW-1:0] view_idx
);

  localparam logic [LW:0]   LAP_FULL = (LW+1)'(LAP_DEPTH);
  localparam logic [LW:0]   CNT_ONE  = 1;
  localparam logic [LW-1:0] PTR_ONE  = 1;

  sw_time_t      count;
  sw_time_t      load_value;
  sw_time_t      preset_clamped;
  sw_time_t      preset_latched;
  sw_time_t      preset_nxt;
  logic          cnt_load;
  logic          cnt_inc;
  logic          cnt_dec;
  logic          is_zero;
  logic          is_max;
  logic          reload_ok;
  logic          running_nxt;
  logic          mode_nxt;
  logic          done_nxt;
  logic          viewing_nxt;
  logic          event_nxt;
  logic          lap_we;
  logic [LW:0]   lap_count_nxt;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] wr_ptr_nxt;
  logic [LW-1:0] view_idx_nxt;
  logic [LW-1:0] rd_addr;
  sw_time_t      lap_mem [LAP_DEPTH];

  bcd_time_counter #(
    .MIN_TENS_MAX(MIN_TENS_MAX)
  ) counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(load_value),
    .inc       (cnt_inc),
    .dec       (cnt_dec),
    .value     (count),
    .is_zero   (is_zero),
    .is_max    (is_max)
  );

  assign preset_clamped = clamp_preset(preset_bcd, bcd_t'(MIN_TENS_MAX));
  assign reload_ok      = repeat_en && (preset_latched != TIME_ZERO);
  assign rd_addr        = wr_ptr - PTR_ONE - view_idx;
  assign disp_bcd       = viewing_lap ? lap_mem[rd_addr] : count;

  // Tick handling first, then at most one command in priority order.
  always_comb begin
    running_nxt   = running;
    mode_nxt      = mode_timer;
    done_nxt      = done;
    viewing_nxt   = viewing_lap;
    event_nxt     = 1'b0;
    lap_count_nxt = lap_count;
    wr_ptr_nxt    = wr_ptr;
    view_idx_nxt  = view_idx;
    preset_nxt    = preset_latched;
    cnt_load      = 1'b0;
    cnt_inc       = 1'b0;
    cnt_dec       = 1'b0;
    load_value    = preset_latched;
    lap_we        = 1'b0;

    if (tick && running) begin
      if (!mode_timer) begin
        if (is_max) begin
          event_nxt = 1'b1;
          if (SATURATE) begin
            running_nxt = 1'b0;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end else if (is_zero) begin
        // Only reachable after an auto-repeat expiry: reload or finally stop.
        if (reload_ok) begin
          cnt_load  = 1'b1;
          event_nxt = 1'b1;
        end else begin
          running_nxt = 1'b0;
          done_nxt    = 1'b1;
        end
      end else begin
        cnt_dec = 1'b1;
        if (count == TIME_ONE_CC) begin
          event_nxt = 1'b1;
          if (!reload_ok) begin
            running_nxt = 1'b0;
            done_nxt    = 1'b1;
          end
        end
      end
    end

    if (cmd_clear) begin
      if (!running) begin
        cnt_load      = 1'b1;
        load_value    = TIME_ZERO;
        lap_count_nxt = '0;
        wr_ptr_nxt    = '0;
        view_idx_nxt  = '0;
        viewing_nxt   = 1'b0;
        done_nxt      = 1'b0;
      end
    end else if (cmd_stop) begin
      running_nxt = 1'b0;
      viewing_nxt = 1'b0;
    end else if (cmd_start) begin
      viewing_nxt = 1'b0;
      if (!running && !done && !(mode_timer && is_zero)) begin
        running_nxt = 1'b1;
      end
    end else if (cmd_load) begin
      if (mode_timer && !running) begin
        cnt_load   = 1'b1;
        load_value = preset_clamped;
        preset_nxt = preset_clamped;
        done_nxt   = 1'b0;
      end
    end else if (cmd_mode) begin
      if (!running) begin
        mode_nxt = !mode_timer;
        done_nxt = 1'b0;
      end
    end else if (cmd_lap) begin
      if (running) begin
        lap_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (lap_count != LAP_FULL) begin
          lap_count_nxt = lap_count + CNT_ONE;
        end
      end else if (lap_count != '0) begin
        if (!viewing_lap) begin
          viewing_nxt  = 1'b1;
          view_idx_nxt = '0;
        end else if (({1'b0, view_idx} + CNT_ONE) == lap_count) begin
          view_idx_nxt = '0;
        end else begin
          view_idx_nxt = view_idx + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running        <= 1'b0;
      mode_timer     <= 1'b0;
      done           <= 1'b0;
      viewing_lap    <= 1'b0;
      event_pulse    <= 1'b0;
      lap_count      <= '0;
      wr_ptr         <= '0;
      view_idx       <= '0;
      preset_latched <= TIME_ZERO;
    end else begin
      running        <= running_nxt;
      mode_timer     <= mode_nxt;
      done           <= done_nxt;
      viewing_lap    <= viewing_nxt;
      event_pulse    <= event_nxt;
      lap_count      <= lap_count_nxt;
      wr_ptr         <= wr_ptr_nxt;
      view_idx       <= view_idx_nxt;
      preset_latched <= preset_nxt;
    end
  end

  // Lap capture stores the count as it was before this edge's tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_mem[i] <= TIME_ZERO;
      end
    end else if (lap_we) begin
      lap_mem[wr_ptr] <= count;
    end
  end

endmodule

// File: tb/tb_stopwatch_core_gen.sv
// Self-checking bench for stopwatch_core_gen: vector table, directed corner
// sequences and randomized traffic against a centisecond/queue reference model.
module tb_stopwatch_core_gen;

  localparam int LAP_DEPTH = 4;
  localparam int MTM       = 5;
  localparam int LW        = $clog2(LAP_DEPTH);
  localparam int MAX_CS    = (MTM * 10 + 9) * 6000 + 5999;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_TICK  = 7'b1000000;
  localparam logic [6:0] C_CLEAR = 7'b0100000;
  localparam logic [6:0] C_STOP  = 7'b0010000;
  localparam logic [6:0] C_START = 7'b0001000;
  localparam logic [6:0] C_LOAD  = 7'b0000100;
  localparam logic [6:0] C_MODE  = 7'b0000010;
  localparam logic [6:0] C_LAP   = 7'b0000001;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick, cmd_start, cmd_stop, cmd_load, cmd_mode, cmd_lap, cmd_clear;
  logic          repeat_en;
  logic [15:0]   preset_bcd;
  logic [23:0]   disp_bcd, disp_s;
  logic          running, mode_timer, done, event_pulse, viewing_lap;
  logic          running_s, mode_s, done_s, event_s, viewing_s;
  logic [LW:0]   lap_count, lap_count_s;
  logic [LW-1:0] view_idx, view_idx_s;

  int n_checks;
  int n_fail;

  int m_cs, m_preset, m_vidx;
  bit m_run, m_mode, m_done, m_view, m_evt;
  int laps[$];

  typedef struct {
    logic [6:0]    cmd;
    logic [15:0]   preset;
    logic [23:0]   disp;
    logic          run;
    logic          mode;
    logic          dn;
    logic          evt;
    logic [LW:0]   lcnt;
    logic          view;
    logic [LW-1:0] vidx;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  stopwatch_core_gen #(.LAP_DEPTH(LAP_DEPTH), .MIN_TENS_MAX(MTM), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_load(cmd_load), .cmd_mode(cmd_mode), .cmd_lap(cmd_lap), .cmd_clear(cmd_clear),
    .repeat_en(repeat_en), .preset_bcd(preset_bcd), .disp_bcd(disp_bcd), .running(running),
    .mode_timer(mode_timer), .done(done), .event_pulse(event_pulse), .lap_count(lap_count),
    .viewing_lap(viewing_lap), .view_idx(view_idx)
  );

  stopwatch_core_gen #(.LAP_DEPTH(LAP_DEPTH), .MIN_TENS_MAX(MTM), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_load(cmd_load), .cmd_mode(cmd_mode), .cmd_lap(cmd_lap), .cmd_clear(cmd_clear),
    .repeat_en(repeat_en), .preset_bcd(preset_bcd), .disp_bcd(disp_s), .running(running_s),
    .mode_timer(mode_s), .done(done_s), .event_pulse(event_s), .lap_count(lap_count_s),
    .viewing_lap(viewing_s), .view_idx(view_idx_s)
  );

  function automatic int clamp_cs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = int'(p[15:12]); if (mt > MTM) mt = MTM;
    mo = int'(p[11:8]);  if (mo > 9)   mo = 9;
    st = int'(p[7:4]);   if (st > 5)   st = 5;
    so = int'(p[3:0]);   if (so > 9)   so = 9;
    return (mt * 10 + mo) * 6000 + (st * 10 + so) * 100;
  endfunction

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [23:0] exp_disp();
    if (m_view) return to_bcd(laps[laps.size() - 1 - m_vidx]);
    return to_bcd(m_cs);
  endfunction

  task automatic model_reset();
    m_cs = 0; m_preset = 0; m_vidx = 0;
    m_run = 0; m_mode = 0; m_done = 0; m_view = 0; m_evt = 0;
    laps.delete();
  endtask

  // Count kept as total centiseconds; laps as a queue, newest at the back.
  task automatic model_step(input logic [6:0] c);
    int n_cs, n_preset, n_vidx;
    bit n_run, n_mode, n_done, n_view, rel;
    n_cs = m_cs; n_preset = m_preset; n_vidx = m_vidx;
    n_run = m_run; n_mode = m_mode; n_done = m_done; n_view = m_view;
    m_evt = 0;
    rel = repeat_en && (m_preset != 0);
    if (c[6] && m_run) begin
      if (!m_mode) begin
        if (m_cs == MAX_CS) begin
          m_evt = 1;
          if (0) n_run = 0; else n_cs = 0;
        end else n_cs = m_cs + 1;
      end else if (m_cs == 0) begin
        if (rel) begin n_cs = m_preset; m_evt = 1; end
        else begin n_run = 0; n_done = 1; end
      end else begin
        n_cs = m_cs - 1;
        if (n_cs == 0) begin
          m_evt = 1;
          if (!rel) begin n_run = 0; n_done = 1; end
        end
      end
    end
    if (c[5]) begin
      if (!m_run) begin n_cs = 0; laps.delete(); n_view = 0; n_vidx = 0; n_done = 0; end
    end else if (c[4]) begin
      n_run = 0; n_view = 0;
    end else if (c[3]) begin
      n_view = 0;
      if (!m_run && !m_done && !(m_mode && m_cs == 0)) n_run = 1;
    end else if (c[2]) begin
      if (m_mode && !m_run) begin
        n_cs = clamp_cs(preset_bcd); n_preset = n_cs; n_done = 0;
      end
    end else if (c[1]) begin
      if (!m_run) begin n_mode = !m_mode; n_done = 0; end
    end else if (c[0]) begin
      if (m_run) begin
        laps.push_back(m_cs);
        if (laps.size() > LAP_DEPTH) void'(laps.pop_front());
      end else if (laps.size() > 0) begin
        if (!m_view) begin n_view = 1; n_vidx = 0; end
        else n_vidx = (m_vidx + 1) % laps.size();
      end
    end
    m_cs = n_cs; m_preset = n_preset; m_vidx = n_vidx;
    m_run = n_run; m_mode = n_mode; m_done = n_done; m_view = n_view;
  endtask

  task automatic apply_stimulus(input logic [6:0] c);
    {tick, cmd_clear, cmd_stop, cmd_start, cmd_load, cmd_mode, cmd_lap} = c;
    @(posedge clk);
    #1;
    model_step(c);
    {tick, cmd_clear, cmd_stop, cmd_start, cmd_load, cmd_mode, cmd_lap} = C_NONE;
  endtask

  task automatic apply_reset();
    {tick, cmd_clear, cmd_stop, cmd_start, cmd_load, cmd_mode, cmd_lap} = C_NONE;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(C_TICK);
  endtask

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_field({tag, ".disp"},     32'(disp_bcd),    32'(exp_disp()));
    check_field({tag, ".running"},  32'(running),     32'(m_run));
    check_field({tag, ".mode"},     32'(mode_timer),  32'(m_mode));
    check_field({tag, ".done"},     32'(done),        32'(m_done));
    check_field({tag, ".event"},    32'(event_pulse), 32'(m_evt));
    check_field({tag, ".lapcnt"},   32'(lap_count),   32'(laps.size()));
    check_field({tag, ".viewing"},  32'(viewing_lap), 32'(m_view));
    if (m_view) check_field({tag, ".viewidx"}, 32'(view_idx), 32'(m_vidx));
  endtask

  initial begin
    int ev;
    logic [6:0]  c;
    logic [23:0] order [5];
    n_checks = 0;
    n_fail   = 0;
    repeat_en  = 1'b0;
    preset_bcd = 16'h0000;
    rst        = 1'b0;

    vecs[0]  = '{C_MODE,          16'h0000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[1]  = '{C_LOAD,          16'h7A9C, 24'h595900, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[2]  = '{C_LOAD,          16'h0001, 24'h000100, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[3]  = '{C_START,         16'h0001, 24'h000100, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[4]  = '{C_TICK,          16'h0001, 24'h000099, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[5]  = '{C_TICK | C_LAP,  16'h0001, 24'h000098, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0};
    vecs[6]  = '{C_STOP,          16'h0001, 24'h000098, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0};
    vecs[7]  = '{C_LAP,           16'h0001, 24'h000099, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0};
    vecs[8]  = '{C_LAP,           16'h0001, 24'h000099, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0};
    vecs[9]  = '{C_MODE,          16'h0001, 24'h000099, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0};
    vecs[10] = '{C_CLEAR|C_START, 16'h0001, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[11] = '{C_START,         16'h0001, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[12] = '{C_TICK,          16'h0001, 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[13] = '{C_TICK | C_STOP, 16'h0001, 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[14] = '{C_TICK,          16'h0001, 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    vecs[15] = '{C_START|C_LOAD,  16'h0001, 24'h000002, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};

    apply_reset();
    check_field("reset.disp",    32'(disp_bcd),    32'h0);
    check_field("reset.running", 32'(running),     32'h0);
    check_field("reset.lapcnt",  32'(lap_count),   32'h0);
    check_output("reset");

    for (int i = 0; i < 16; i++) begin
      preset_bcd = vecs[i].preset;
      apply_stimulus(vecs[i].cmd);
      check_field($sformatf("vec%0d.disp", i),    32'(disp_bcd),    32'(vecs[i].disp));
      check_field($sformatf("vec%0d.running", i), 32'(running),     32'(vecs[i].run));
      check_field($sformatf("vec%0d.mode", i),    32'(mode_timer),  32'(vecs[i].mode));
      check_field($sformatf("vec%0d.done", i),    32'(done),        32'(vecs[i].dn));
      check_field($sformatf("vec%0d.event", i),   32'(event_pulse), 32'(vecs[i].evt));
      check_field($sformatf("vec%0d.lapcnt", i),  32'(lap_count),   32'(vecs[i].lcnt));
      check_field($sformatf("vec%0d.viewing", i), 32'(viewing_lap), 32'(vecs[i].view));
      check_field($sformatf("vec%0d.viewidx", i), 32'(view_idx),    32'(vecs[i].vidx));
    end

    // Up-count with two laps, then browse them while stopped.
    apply_reset();
    apply_stimulus(C_START);
    run_ticks(150);
    check_field("up150.disp", 32'(disp_bcd), 32'h000150);
    apply_stimulus(C_LAP);
    run_ticks(150);
    check_field("up300.disp", 32'(disp_bcd), 32'h000300);
    apply_stimulus(C_LAP);
    apply_stimulus(C_STOP);
    apply_stimulus(C_LAP);
    check_field("view0.disp",    32'(disp_bcd),    32'h000300);
    check_field("view0.viewing", 32'(viewing_lap), 32'h1);
    apply_stimulus(C_LAP);
    check_field("view1.disp", 32'(disp_bcd), 32'h000150);
    check_field("view1.idx",  32'(view_idx), 32'h1);
    apply_stimulus(C_LAP);
    check_field("view2.disp", 32'(disp_bcd), 32'h000300);
    check_field("view2.idx",  32'(view_idx), 32'h0);

    // Overfill the lap buffer: oldest two entries are overwritten.
    apply_reset();
    apply_stimulus(C_START);
    for (int k = 0; k < 6; k++) begin
      run_ticks(10);
      apply_stimulus(C_LAP);
    end
    apply_stimulus(C_STOP);
    order = '{24'h000060, 24'h000050, 24'h000040, 24'h000030, 24'h000060};
    for (int j = 0; j < 5; j++) begin
      apply_stimulus(C_LAP);
      check_field($sformatf("ovf%0d.disp", j), 32'(disp_bcd), 32'(order[j]));
    end
    check_field("ovf.lapcnt", 32'(lap_count), 32'h4);

    // Timer expiry without repeat.
    apply_reset();
    apply_stimulus(C_MODE);
    preset_bcd = 16'h0001;
    apply_stimulus(C_LOAD);
    apply_stimulus(C_START);
    ev = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(C_TICK);
      ev += int'(event_pulse);
    end
    check_field("timer.disp",    32'(disp_bcd), 32'h0);
    check_field("timer.done",    32'(done),     32'h1);
    check_field("timer.running", 32'(running),  32'h0);
    check_field("timer.events",  32'(ev),       32'h1);
    apply_stimulus(C_START);
    check_field("timer.restart", 32'(running),  32'h0);

    // Timer auto-repeat reloads on the tick after reaching zero.
    apply_reset();
    repeat_en  = 1'b1;
    preset_bcd = 16'h0001;
    apply_stimulus(C_MODE);
    apply_stimulus(C_LOAD);
    apply_stimulus(C_START);
    run_ticks(99);
    apply_stimulus(C_TICK);
    check_field("rpt.zero.disp",  32'(disp_bcd),    32'h0);
    check_field("rpt.zero.event", 32'(event_pulse), 32'h1);
    check_field("rpt.zero.run",   32'(running),     32'h1);
    check_field("rpt.zero.done",  32'(done),        32'h0);
    apply_stimulus(C_TICK);
    check_field("rpt.reload.disp", 32'(disp_bcd), 32'h000100);
    check_field("rpt.reload.run",  32'(running),  32'h1);
    apply_stimulus(C_TICK);
    check_field("rpt.after.disp",  32'(disp_bcd), 32'h000099);
    repeat_en = 1'b0;

    // Top of range: wrap in one instance, saturate in the other.
    apply_reset();
    preset_bcd = 16'h5959;
    apply_stimulus(C_MODE);
    apply_stimulus(C_LOAD);
    apply_stimulus(C_MODE);
    apply_stimulus(C_START);
    run_ticks(99);
    check_field("max.disp",     32'(disp_bcd), 32'h595999);
    check_field("max.disp_sat", 32'(disp_s),   32'h595999);
    apply_stimulus(C_TICK);
    check_field("wrap.disp",    32'(disp_bcd),    32'h0);
    check_field("wrap.event",   32'(event_pulse), 32'h1);
    check_field("wrap.run",     32'(running),     32'h1);
    check_field("sat.disp",     32'(disp_s),      32'h595999);
    check_field("sat.event",    32'(event_s),     32'h1);
    check_field("sat.run",      32'(running_s),   32'h0);

    // Reset in the middle of a run.
    apply_reset();
    apply_stimulus(C_START);
    run_ticks(37);
    apply_stimulus(C_LAP);
    apply_reset();
    check_field("midrst.disp",    32'(disp_bcd),    32'h0);
    check_field("midrst.running", 32'(running),     32'h0);
    check_field("midrst.mode",    32'(mode_timer),  32'h0);
    check_field("midrst.lapcnt",  32'(lap_count),   32'h0);
    check_field("midrst.event",   32'(event_pulse), 32'h0);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        apply_reset();
        check_output("rnd.rst");
      end
      c = C_NONE;
      c[6] = ($urandom_range(3) != 0);
      if ($urandom_range(59) == 0) c[5] = 1'b1;
      if ($urandom_range(24) == 0) c[4] = 1'b1;
      if ($urandom_range(11) == 0) c[3] = 1'b1;
      if ($urandom_range(14) == 0) c[2] = 1'b1;
      if ($urandom_range(19) == 0) c[1] = 1'b1;
      if ($urandom_range(7) == 0)  c[0] = 1'b1;
      if ($urandom_range(99) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(19) == 0)
        preset_bcd = ($urandom_range(1) == 0) ? 16'($urandom_range(3)) : 16'($urandom);
      apply_stimulus(c);
      check_output("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
